fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the forwarding (redirect) pipelined CPU.
- Holds the PC and drives the instruction-memory word address.
- Latches the fetched instruction and PC+4 into IF/ID, where the ID-stage decoder consumes them.
- Handles load-use stall, branch/jump redirect with flush, and syscall halt/resume.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_AW, 10, instruction-memory word-address width; IM_ADDR = PC[IM_AW+1:2].

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- STALL  in  1  load-use hazard; freeze PC and IF/ID.
- REDIRECT  in  1  taken branch/jump/jr resolved downstream; load new PC and flush IF/ID.
- REDIRECT_PC  in  32  redirect target byte address.
- HALT  in  1  syscall-halt request; freeze fetch until GO.
- GO  in  1  single-cycle resume pulse.
- IM_DATA  in  32  combinational instruction-memory read data for IM_ADDR.
- IM_ADDR  out  IM_AW  word address = PC[IM_AW+1:2].
- PC_IF  out  32  current fetch PC.
- IR_ID  out  32  IF/ID instruction; feeds the decoder CODE input.
- PC4_ID  out  32  IF/ID PC+4.
- VALID_ID  out  1  IF/ID holds a real instruction; 0 means bubble.
- HALTED  out  1  halt flag.

Behaviour:
- All registers are synchronous and active-high reset (rst). Reset values:
  - PC = RESET_PC.
  - IR_ID = 0 (sll $0 = nop).
  - PC4_ID = 0, VALID_ID = 0, HALTED = 0.
- rst overrides every other input in the same cycle, including mid-stall and mid-halt.
- Fetch latency: IM_DATA is combinational from IM_ADDR. The instruction at PC appears on IR_ID one cycle after PC_IF = PC.
- PC arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.
  - REDIRECT_PC[1:0] is forced to 2'b00 on load.
- Two states: RUN and HALT (HALTED = 1 in HALT). Per-edge priority, highest first:
  1. rst: reset values as above.
  2. REDIRECT=1 (any state):
     - PC <= {REDIRECT_PC[31:2], 2'b00}.
     - IF/ID <= bubble (IR_ID = 0, VALID_ID = 0, PC4_ID unchanged).
     - If HALT is also 1, state <= HALT; otherwise the state is unchanged.
     - REDIRECT overrides STALL.
  3. HALT=1 (RUN or HALT state): state <= HALT, PC held, IF/ID <= bubble.
     - HALT and GO in the same cycle: HALT wins.
  4. State HALT with GO=1: state <= RUN, PC held, IF/ID <= bubble.
     - Fetch resumes from the held PC; IR_ID is valid on the second edge after GO.
  5. State HALT, otherwise: PC held, IF/ID <= bubble.
  6. STALL=1 in RUN: PC held, IR_ID/PC4_ID/VALID_ID held.
  7. RUN, no event: PC <= PC+4, IR_ID <= IM_DATA, PC4_ID <= PC+4, VALID_ID <= 1.
- STALL is ignored in the HALT state.
- A continuously asserted STALL holds the IF/ID contents indefinitely.
- IM_ADDR and PC_IF are combinational from the PC register. No combinational path from inputs to outputs.

Optional Feature:
- Macro FETCH_STAT_EN.
- Defined:
  - Adds outputs CYCLE_CNT[31:0], STALL_CNT[31:0], FLUSH_CNT[31:0]; all reset to 0 and wrap at 2^32.
  - CYCLE_CNT increments every non-reset cycle while not HALTED.
  - STALL_CNT increments on a priority-6 hold edge.
  - FLUSH_CNT increments on every REDIRECT edge.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset then run: rst=1 for 2 cycles, memory word0=32'h2008_0005, word1=32'h2009_000A.
  - Cycle 1 after release: IR_ID=32'h2008_0005, PC4_ID=4, VALID_ID=1.
  - Cycle 2: IR_ID=32'h2009_000A, PC4_ID=8, PC_IF=8.
- Stall: STALL=1 for 3 cycles at PC=8 → PC_IF stays 8 and IR_ID stays constant for 3 edges. With FETCH_STAT_EN, STALL_CNT=3.
- Redirect over stall: REDIRECT=1, REDIRECT_PC=32'h0000_0043, STALL=1 → next PC_IF=32'h40, IR_ID=0, VALID_ID=0, IM_ADDR=16.
- Halt/resume: HALT pulse at PC=12 → HALTED=1 and PC_IF=12 held for 5 cycles with VALID_ID=0. GO pulse → HALTED=0 next edge; VALID_ID=1 with IR_ID=mem[3] one edge later.
- HALT and GO in the same cycle while halted → HALTED remains 1.
- Wrap and mid-op reset: REDIRECT_PC=32'hFFFF_FFFC → next PC_IF=0 after one RUN edge. rst asserted during HALT → PC_IF=RESET_PC, HALTED=0, IR_ID=0 on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, load-use stall, redirect flush, syscall halt/resume.
// Optional performance counters are enabled with the FETCH_STAT_EN macro.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             STALL,
    input  logic             REDIRECT,
    input  logic [31:0]      REDIRECT_PC,
    input  logic             HALT,
    input  logic             GO,
    input  logic [31:0]      IM_DATA,
    output logic [IM_AW-1:0] IM_ADDR,
    output logic [31:0]      PC_IF,
    output logic [31:0]      IR_ID,
    output logic [31:0]      PC4_ID,
    output logic             VALID_ID,
    output logic             HALTED
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]      CYCLE_CNT,
    output logic [31:0]      STALL_CNT,
    output logic [31:0]      FLUSH_CNT
`endif
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    function automatic logic [31:0] inc_pc(input logic [31:0] pc);
        inc_pc = pc + 32'd4;
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        align_pc = pc & 32'hFFFF_FFFC;
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc4_q, pc4_d;
    logic        vld_q, vld_d;
    logic [0:0]  state_q, state_d;
    logic        hold_edge;

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        pc4_d     = pc4_q;
        vld_d     = vld_q;
        state_d   = state_q;
        hold_edge = 1'b0;
        if (REDIRECT) begin
            pc_d  = align_pc(REDIRECT_PC);
            ir_d  = 32'd0;
            vld_d = 1'b0;
            if (HALT) state_d = S_HALT;
        end else if (HALT) begin
            state_d = S_HALT;
            ir_d    = 32'd0;
            vld_d   = 1'b0;
        end else if (state_q == S_HALT) begin
            // PC is held so fetch resumes exactly where it stopped
            if (GO) state_d = S_RUN;
            ir_d  = 32'd0;
            vld_d = 1'b0;
        end else if (STALL) begin
            hold_edge = 1'b1;
        end else begin
            pc_d  = inc_pc(pc_q);
            ir_d  = IM_DATA;
            pc4_d = inc_pc(pc_q);
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            pc4_q   <= 32'd0;
            vld_q   <= 1'b0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
            state_q <= state_d;
        end
    end

`ifdef FETCH_STAT_EN
    logic [31:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (state_q == S_RUN) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (hold_edge)        stall_cnt_q <= stall_cnt_q + 32'd1;
            if (REDIRECT)         flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign CYCLE_CNT = cycle_cnt_q;
    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

    assign IM_ADDR  = pc_q[IM_AW+1:2];
    assign PC_IF    = pc_q;
    assign IR_ID    = ir_q;
    assign PC4_ID   = pc4_q;
    assign VALID_ID = vld_q;
    assign HALTED   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a reference model.
module tb_fetch_stage;
    localparam int IM_AW = 10;

    logic             clk = 1'b0;
    logic             rst, STALL, REDIRECT, HALT, GO;
    logic [31:0]      REDIRECT_PC, IM_DATA;
    logic [IM_AW-1:0] IM_ADDR;
    logic [31:0]      PC_IF, IR_ID, PC4_ID;
    logic             VALID_ID, HALTED;
`ifdef FETCH_STAT_EN
    logic [31:0]      CYCLE_CNT, STALL_CNT, FLUSH_CNT;
`endif

    logic [31:0] mem [0:(1<<IM_AW)-1];
    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;
    assign IM_DATA = mem[IM_ADDR];

    fetch_stage #(.RESET_PC(32'h0000_0000), .IM_AW(IM_AW)) dut (
        .clk(clk), .rst(rst), .STALL(STALL), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .HALT(HALT), .GO(GO), .IM_DATA(IM_DATA),
        .IM_ADDR(IM_ADDR), .PC_IF(PC_IF), .IR_ID(IR_ID), .PC4_ID(PC4_ID),
        .VALID_ID(VALID_ID), .HALTED(HALTED)
`ifdef FETCH_STAT_EN
        , .CYCLE_CNT(CYCLE_CNT), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; STALL = 0; REDIRECT = 0; REDIRECT_PC = 0; HALT = 0; GO = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        asserts++; if (PC_IF !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want %h", PC_IF, 32'h0); end
        asserts++; if (IR_ID !== 32'h0) begin fails++; $display("FAIL reset_ir got %h want %h", IR_ID, 32'h0); end
        asserts++; if (PC4_ID !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h want %h", PC4_ID, 32'h0); end
        asserts++; if (VALID_ID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", VALID_ID); end
        asserts++; if (HALTED !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", HALTED); end
        asserts++; if (IM_ADDR !== 10'd0) begin fails++; $display("FAIL reset_imaddr got %0d want 0", IM_ADDR); end
        rst = 0;
    endtask

    task automatic test_run();
        tick();
        asserts++; if (IR_ID !== 32'h2008_0005) begin fails++; $display("FAIL run1_ir got %h want %h", IR_ID, 32'h2008_0005); end
        asserts++; if (PC4_ID !== 32'd4) begin fails++; $display("FAIL run1_pc4 got %h want 4", PC4_ID); end
        asserts++; if (VALID_ID !== 1'b1) begin fails++; $display("FAIL run1_valid got %b want 1", VALID_ID); end
        tick();
        asserts++; if (IR_ID !== 32'h2009_000A) begin fails++; $display("FAIL run2_ir got %h want %h", IR_ID, 32'h2009_000A); end
        asserts++; if (PC4_ID !== 32'd8) begin fails++; $display("FAIL run2_pc4 got %h want 8", PC4_ID); end
        asserts++; if (PC_IF !== 32'd8) begin fails++; $display("FAIL run2_pc got %h want 8", PC_IF); end
    endtask

    task automatic test_stall();
        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++; if (PC_IF !== 32'd8) begin fails++; $display("FAIL stall_pc[%0d] got %h want 8", i, PC_IF); end
            asserts++; if (IR_ID !== 32'h2009_000A) begin fails++; $display("FAIL stall_ir[%0d] got %h want %h", i, IR_ID, 32'h2009_000A); end
            asserts++; if (VALID_ID !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, VALID_ID); end
        end
`ifdef FETCH_STAT_EN
        asserts++; if (STALL_CNT !== 32'd3) begin fails++; $display("FAIL stall_cnt got %0d want 3", STALL_CNT); end
`endif
    endtask

    task automatic test_redirect_over_stall();
        STALL = 1; REDIRECT = 1; REDIRECT_PC = 32'h0000_0043;
        tick();
        idle();
        asserts++; if (PC_IF !== 32'h40) begin fails++; $display("FAIL redir_pc got %h want 40", PC_IF); end
        asserts++; if (IR_ID !== 32'h0) begin fails++; $display("FAIL redir_ir got %h want 0", IR_ID); end
        asserts++; if (VALID_ID !== 1'b0) begin fails++; $display("FAIL redir_valid got %b want 0", VALID_ID); end
        asserts++; if (IM_ADDR !== 10'd16) begin fails++; $display("FAIL redir_imaddr got %0d want 16", IM_ADDR); end
        asserts++; if (PC4_ID !== 32'd8) begin fails++; $display("FAIL redir_pc4 got %h want 8", PC4_ID); end
`ifdef FETCH_STAT_EN
        asserts++; if (FLUSH_CNT !== 32'd1) begin fails++; $display("FAIL flush_cnt got %0d want 1", FLUSH_CNT); end
`endif
    endtask

    task automatic test_halt_resume();
        REDIRECT = 1; REDIRECT_PC = 32'd12;
        tick();
        idle(); HALT = 1;
        tick();
        HALT = 0;
        for (int i = 0; i < 5; i++) begin
            STALL = (i == 2);
            tick();
            asserts++; if (HALTED !== 1'b1) begin fails++; $display("FAIL halt_flag[%0d] got %b want 1", i, HALTED); end
            asserts++; if (PC_IF !== 32'd12) begin fails++; $display("FAIL halt_pc[%0d] got %h want c", i, PC_IF); end
            asserts++; if (VALID_ID !== 1'b0) begin fails++; $display("FAIL halt_valid[%0d] got %b want 0", i, VALID_ID); end
        end
        STALL = 0; GO = 1;
        tick();
        GO = 0;
        asserts++; if (HALTED !== 1'b0) begin fails++; $display("FAIL go_flag got %b want 0", HALTED); end
        asserts++; if (VALID_ID !== 1'b0) begin fails++; $display("FAIL go_valid got %b want 0", VALID_ID); end
        tick();
        asserts++; if (VALID_ID !== 1'b1) begin fails++; $display("FAIL resume_valid got %b want 1", VALID_ID); end
        asserts++; if (IR_ID !== mem[3]) begin fails++; $display("FAIL resume_ir got %h want %h", IR_ID, mem[3]); end
        asserts++; if (PC4_ID !== 32'd16) begin fails++; $display("FAIL resume_pc4 got %h want 10", PC4_ID); end
    endtask

    task automatic test_halt_go_same();
        HALT = 1;
        tick();
        GO = 1;
        tick();
        asserts++; if (HALTED !== 1'b1) begin fails++; $display("FAIL halt_go_flag got %b want 1", HALTED); end
        HALT = 0;
        tick();
        GO = 0;
        asserts++; if (HALTED !== 1'b0) begin fails++; $display("FAIL go_after_flag got %b want 0", HALTED); end
    endtask

    task automatic test_wrap();
        REDIRECT = 1; REDIRECT_PC = 32'hFFFF_FFFC;
        tick();
        REDIRECT = 0;
        asserts++; if (IM_ADDR !== 10'h3FF) begin fails++; $display("FAIL wrap_imaddr got %h want 3ff", IM_ADDR); end
        tick();
        asserts++; if (PC_IF !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h want 0", PC_IF); end
        asserts++; if (PC4_ID !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h want 0", PC4_ID); end
        asserts++; if (IR_ID !== mem[1023]) begin fails++; $display("FAIL wrap_ir got %h want %h", IR_ID, mem[1023]); end
    endtask

    task automatic test_reset_mid_halt();
        HALT = 1;
        tick();
        asserts++; if (HALTED !== 1'b1) begin fails++; $display("FAIL prerst_halt got %b want 1", HALTED); end
        rst = 1;
        tick();
        idle();
        asserts++; if (PC_IF !== 32'h0) begin fails++; $display("FAIL rsthalt_pc got %h want 0", PC_IF); end
        asserts++; if (HALTED !== 1'b0) begin fails++; $display("FAIL rsthalt_flag got %b want 0", HALTED); end
        asserts++; if (IR_ID !== 32'h0) begin fails++; $display("FAIL rsthalt_ir got %h want 0", IR_ID); end
    endtask

    // Reference model: architectural fetch state advanced by the priority rules each edge
    task automatic test_random();
        logic [31:0] m_pc, m_ir, m_pc4, nxt;
        logic        m_vld, m_halt;
        int          m_cyc, m_stl, m_fl;
        rst = 1; tick(); idle();
        m_pc = 0; m_ir = 0; m_pc4 = 0; m_vld = 0; m_halt = 0;
        m_cyc = 0; m_stl = 0; m_fl = 0;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            STALL       = ($urandom_range(0, 99) < 35);
            REDIRECT    = ($urandom_range(0, 99) < 10);
            HALT        = ($urandom_range(0, 99) < 6);
            GO          = ($urandom_range(0, 99) < 20);
            REDIRECT_PC = $urandom;
            nxt = m_pc + 32'd4;
            if (rst) begin
                m_pc = 0; m_ir = 0; m_pc4 = 0; m_vld = 0; m_halt = 0;
                m_cyc = 0; m_stl = 0; m_fl = 0;
            end else begin
                if (!m_halt) m_cyc++;
                if (REDIRECT) begin
                    m_fl++;
                    m_pc = {REDIRECT_PC[31:2], 2'b00}; m_ir = 0; m_vld = 0;
                    if (HALT) m_halt = 1;
                end else if (HALT) begin
                    m_halt = 1; m_ir = 0; m_vld = 0;
                end else if (m_halt) begin
                    if (GO) m_halt = 0;
                    m_ir = 0; m_vld = 0;
                end else if (STALL) begin
                    m_stl++;
                end else begin
                    m_ir = mem[m_pc[IM_AW+1:2]]; m_pc4 = nxt; m_pc = nxt; m_vld = 1;
                end
            end
            tick();
            asserts++; if (PC_IF !== m_pc) begin fails++; $display("FAIL rnd_pc[%0d] got %h want %h", n, PC_IF, m_pc); end
            asserts++; if (IR_ID !== m_ir) begin fails++; $display("FAIL rnd_ir[%0d] got %h want %h", n, IR_ID, m_ir); end
            asserts++; if (PC4_ID !== m_pc4) begin fails++; $display("FAIL rnd_pc4[%0d] got %h want %h", n, PC4_ID, m_pc4); end
            asserts++; if (VALID_ID !== m_vld) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", n, VALID_ID, m_vld); end
            asserts++; if (HALTED !== m_halt) begin fails++; $display("FAIL rnd_halted[%0d] got %b want %b", n, HALTED, m_halt); end
            asserts++; if (IM_ADDR !== m_pc[IM_AW+1:2]) begin fails++; $display("FAIL rnd_imaddr[%0d] got %h want %h", n, IM_ADDR, m_pc[IM_AW+1:2]); end
`ifdef FETCH_STAT_EN
            asserts++; if (CYCLE_CNT !== 32'(m_cyc)) begin fails++; $display("FAIL rnd_cyc[%0d] got %0d want %0d", n, CYCLE_CNT, m_cyc); end
            asserts++; if (STALL_CNT !== 32'(m_stl)) begin fails++; $display("FAIL rnd_stl[%0d] got %0d want %0d", n, STALL_CNT, m_stl); end
            asserts++; if (FLUSH_CNT !== 32'(m_fl)) begin fails++; $display("FAIL rnd_fl[%0d] got %0d want %0d", n, FLUSH_CNT, m_fl); end
`endif
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < (1 << IM_AW); i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_000A;
        test_reset();
        test_run();
        test_stall();
        test_redirect_over_stall();
        test_halt_resume();
        test_halt_go_same();
        test_wrap();
        test_reset_mid_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
